// File: rtl/div_residue_checker.sv
// div_residue_checker: rebuilds n as q*d + r with a shift-add multiplier,
// reports |n - n_hat| and keeps saturating error statistics.
module div_residue_checker #(
   parameter int WIDTH = 8,
   parameter int SUM_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   n,
   input  logic [WIDTH-1:0]     d,
   input  logic [WIDTH-1:0]     q,
   input  logic [WIDTH-1:0]     r,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   n_hat,
   output logic [2*WIDTH-1:0]   abs_err,
   output logic                 exact,
   input  logic                 clear_stats,
   output logic [SUM_W-1:0]     err_sum,
   output logic [CNT_W-1:0]     sample_cnt
);

   localparam int NW = 2 * WIDTH;
   localparam int SW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      ADD,
      HOLD
   } state_t;

   state_t            state_q;
   logic [NW-1:0]     n_q;
   logic [NW-1:0]     d_q;
   logic [WIDTH-1:0]  q_q;
   logic [WIDTH-1:0]  r_q;
   logic [NW-1:0]     prod_q;
   logic [SW-1:0]     step_q;
   logic              add_ph_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [NW-1:0]     n_hat_q;
   logic [NW-1:0]     abs_err_q;
   logic              exact_q;
   logic [SUM_W-1:0]  err_sum_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [NW-1:0]     prod_d;
   logic [NW-1:0]     n_hat_d;
   logic [NW-1:0]     abs_err_d;
   logic [SUM_W:0]    sum_ext;
   logic [SUM_W-1:0]  err_sum_d;
   logic [CNT_W-1:0]  cnt_d;

   // Datapath: one multiply step, reconstruction, error and saturating stats.
   always_comb begin
      prod_d    = q_q[0] ? prod_q + d_q : prod_q;
      n_hat_d   = prod_q + NW'(r_q);
      abs_err_d = (n_q >= n_hat_q) ? n_q - n_hat_q : n_hat_q - n_q;
      sum_ext   = {1'b0, err_sum_q} + (SUM_W+1)'(abs_err_q);
      err_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // Control FSM; ADD spends one edge forming n_hat and one forming the error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         n_q         <= '0;
         d_q         <= '0;
         q_q         <= '0;
         r_q         <= '0;
         prod_q      <= '0;
         step_q      <= '0;
         add_ph_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         n_hat_q     <= '0;
         abs_err_q   <= '0;
         exact_q     <= 1'b0;
         err_sum_q   <= '0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  n_q        <= n;
                  d_q        <= NW'(d);
                  q_q        <= q;
                  r_q        <= r;
                  prod_q     <= '0;
                  step_q     <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= MUL;
               end
            end
            MUL: begin
               prod_q <= prod_d;
               d_q    <= d_q << 1;
               q_q    <= q_q >> 1;
               step_q <= step_q + SW'(1);
               if (step_q == SW'(WIDTH - 1)) begin
                  add_ph_q <= 1'b0;
                  state_q  <= ADD;
               end
            end
            ADD: begin
               if (!add_ph_q) begin
                  n_hat_q  <= n_hat_d;
                  add_ph_q <= 1'b1;
               end else begin
                  abs_err_q   <= abs_err_d;
                  exact_q     <= (n_q == n_hat_q);
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
                  err_sum_q   <= err_sum_d;
                  cnt_q       <= cnt_d;
               end
            end
         endcase
         if (clear_stats) begin
            err_sum_q <= '0;
            cnt_q     <= '0;
         end
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign n_hat      = n_hat_q;
   assign abs_err    = abs_err_q;
   assign exact      = exact_q;
   assign err_sum    = err_sum_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_div_residue_checker.sv
// tb_div_residue_checker: directed and random tuples checked against an
// arithmetic model of reconstruction, error and statistics.
module tb_div_residue_checker;

   localparam int WIDTH = 8;
   localparam int SUM_W = 32;
   localparam int CNT_W = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [2*WIDTH-1:0]  n;
   logic [WIDTH-1:0]    d;
   logic [WIDTH-1:0]    q;
   logic [WIDTH-1:0]    r;
   logic                out_valid;
   logic                out_ready;
   logic [2*WIDTH-1:0]  n_hat;
   logic [2*WIDTH-1:0]  abs_err;
   logic                exact;
   logic                clear_stats;
   logic [SUM_W-1:0]    err_sum;
   logic [CNT_W-1:0]    sample_cnt;

   int errors = 0;
   int checks = 0;
   longint sum_m = 0;
   longint cnt_m = 0;

   div_residue_checker #(.WIDTH(WIDTH), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .n(n), .d(d), .q(q), .r(r),
      .out_valid(out_valid), .out_ready(out_ready),
      .n_hat(n_hat), .abs_err(abs_err), .exact(exact),
      .clear_stats(clear_stats),
      .err_sum(err_sum), .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint model_nhat(input longint nq, input longint nd, input longint nr);
      return nq * nd + nr;
   endfunction

   function automatic longint model_err(input longint nn, input longint nh);
      return (nn >= nh) ? nn - nh : nh - nn;
   endfunction

   task automatic send(input int nn, input int dd, input int qq, input int rr);
      check("in_ready_idle", longint'(in_ready), 1);
      n = 16'(nn); d = 8'(dd); q = 8'(qq); r = 8'(rr);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input int nn, input int dd, input int qq, input int rr);
      int cyc;
      longint nh, ae;
      nh = model_nhat(qq, dd, rr);
      ae = model_err(nn, nh);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check("latency", cyc, 10);
      check("n_hat", longint'(n_hat), nh);
      check("abs_err", longint'(abs_err), ae);
      check("exact", longint'(exact), (ae == 0) ? 1 : 0);
   endtask

   task automatic handshake(input int nn, input int dd, input int qq, input int rr,
                            input bit clr);
      longint ae;
      ae = model_err(nn, model_nhat(qq, dd, rr));
      out_ready = 1'b1;
      clear_stats = clr;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      clear_stats = 1'b0;
      if (clr) begin
         sum_m = 0;
         cnt_m = 0;
      end else begin
         sum_m = (sum_m + ae > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sum_m + ae;
         cnt_m = (cnt_m + 1 > 65535) ? 65535 : cnt_m + 1;
      end
      check("out_valid_drop", longint'(out_valid), 0);
      check("in_ready_rise", longint'(in_ready), 1);
      check("err_sum", longint'(err_sum), sum_m);
      check("sample_cnt", longint'(sample_cnt), cnt_m);
   endtask

   task automatic run(input int nn, input int dd, input int qq, input int rr,
                      input bit clr);
      send(nn, dd, qq, rr);
      wait_result(nn, dd, qq, rr);
      handshake(nn, dd, qq, rr, clr);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      clear_stats = 1'b0;
      n = '0; d = '0; q = '0; r = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_n_hat", longint'(n_hat), 0);
      check("rst_abs_err", longint'(abs_err), 0);
      check("rst_exact", longint'(exact), 0);
      check("rst_err_sum", longint'(err_sum), 0);
      check("rst_cnt", longint'(sample_cnt), 0);

      run(1000, 7, 142, 6, 1'b0);
      run(1000, 7, 140, 3, 1'b0);
      run(65280, 255, 255, 255, 1'b0);
      run(5, 0, 200, 9, 1'b0);

      // Backpressure with ignored input pulses
      send(1234, 10, 123, 3);
      wait_result(1234, 10, 123, 3);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         n = 16'($urandom); d = 8'($urandom); q = 8'($urandom); r = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("bp_out_valid", longint'(out_valid), 1);
         check("bp_in_ready", longint'(in_ready), 0);
         check("bp_n_hat", longint'(n_hat), model_nhat(123, 10, 3));
         check("bp_abs_err", longint'(abs_err), 1);
      end
      in_valid = 1'b0;
      handshake(1234, 10, 123, 3, 1'b0);
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("bp_single_xfer_valid", longint'(out_valid), 0);
      check("bp_single_xfer_cnt", longint'(sample_cnt), cnt_m);

      // Reset during the fourth multiply step
      send(1000, 7, 142, 6);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sum_m = 0;
      cnt_m = 0;
      check("mid_rst_in_ready", longint'(in_ready), 1);
      check("mid_rst_out_valid", longint'(out_valid), 0);
      check("mid_rst_err_sum", longint'(err_sum), 0);
      check("mid_rst_cnt", longint'(sample_cnt), 0);
      check("mid_rst_n_hat", longint'(n_hat), 0);
      run(4321, 13, 77, 12, 1'b0);

      // Statistics from a cleared start
      clear_stats = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_stats = 1'b0;
      sum_m = 0;
      cnt_m = 0;
      check("clr_idle_sum", longint'(err_sum), 0);
      check("clr_idle_cnt", longint'(sample_cnt), 0);
      run(1000, 7, 142, 6, 1'b0);
      run(1000, 7, 140, 3, 1'b0);
      run(1005, 7, 142, 6, 1'b0);
      check("stats_sum22", longint'(err_sum), 22);
      check("stats_cnt3", longint'(sample_cnt), 3);
      run(300, 3, 99, 2, 1'b1);
      check("stats_clr_sum", longint'(err_sum), 0);
      check("stats_clr_cnt", longint'(sample_cnt), 0);

      // Random tuples
      for (int i = 0; i < 20; i++) begin
         int rn, rd, rq, rr;
         rn = int'($urandom_range(0, 65535));
         rd = int'($urandom_range(0, 255));
         rq = int'($urandom_range(0, 255));
         rr = int'($urandom_range(0, 255));
         if (i[1:0] == 2'd0) rn = rq * rd + rr;
         run(rn, rd, rq, rr, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
